// File: rtl/modbus_gpio_converter.sv
// APB3 CSR file bridging a Modbus RTU link to a 32-bit GPIO port.
// It contains a UART (8N1, 16x oversampling), RTU framing with a CRC16 check, and an FC05 write-coil slave that echoes the request.
module modbus_gpio_converter (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [11:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        UART_RX,
  output logic        UART_TX,
  input  logic [31:0] GPIO_DI,
  output logic [31:0] GPIO_DO
);
  localparam logic [11:0] A_DO = 12'h000, A_DI = 12'h004, A_TIMER = 12'h008, A_MSG = 12'h00C;
  localparam logic [11:0] A_CFG0 = 12'h010, A_CFG1 = 12'h014, A_MAP = 12'h018, A_IRQ = 12'h01C;
  localparam logic [11:0] A_SCTRL = 12'h020, A_SIDX = 12'h028, A_SENT = 12'h02C;
  localparam logic [11:0] A_SQTY = 12'h030, A_SWB = 12'h034, A_SRB = 12'h038;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] do_reg, do_next, timer, cfg0, cfg1, map_reg;
  logic [31:0] scan_ctrl, scan_idx, scan_entry, scan_qty, scan_wbase, scan_rbase;
  logic [31:0] di_s1, di_s2;
  logic [15:0] msg_good, msg_err;
  logic [2:0]  irq;
  logic        wr_en;

  logic        do_we;
  logic [31:0] do_wmask, do_wdata;
  logic        stat_crc_err, stat_tx_empty, frame_done, echo_start;

  logic [15:0] tick_cnt, div_m1;
  logic        tick;

  logic        rx_s1, rx_s2, rx_s3, rx_valid, rx_ferr;
  uart_state_t rx_state;
  logic [3:0]  rx_os;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;

  logic [15:0] idle_cnt, thr_ticks;
  logic [19:0] sil_x10;
  logic [11:0] thr_bits;
  logic        silent;

  logic [7:0]  fr_buf [8];
  logic [3:0]  fr_cnt;
  logic        fr_active, fr_ovf, fr_discard, armed;
  logic [15:0] fr_crc;
  logic        addr_ok, cmd_ok;

  logic [7:0]  tx_buf [8];
  uart_state_t tx_state;
  logic [3:0]  tx_os, tx_left;
  logic [2:0]  tx_bit, tx_idx;
  logic [7:0]  tx_sh;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign GPIO_DO = do_reg;
  assign wr_en   = PSEL & PENABLE & PWRITE;

  always_comb begin
    PRDATA = 32'h0;
    case (PADDR)
      A_DO:    PRDATA = do_reg;
      A_DI:    PRDATA = di_s2;
      A_TIMER: PRDATA = timer;
      A_MSG:   PRDATA = {msg_err, msg_good};
      A_CFG0:  PRDATA = cfg0;
      A_CFG1:  PRDATA = cfg1;
      A_MAP:   PRDATA = map_reg;
      A_IRQ:   PRDATA = {29'h0, irq};
      A_SCTRL: PRDATA = scan_ctrl;
      A_SIDX:  PRDATA = scan_idx;
      A_SENT:  PRDATA = scan_entry;
      A_SQTY:  PRDATA = scan_qty;
      A_SWB:   PRDATA = scan_wbase;
      A_SRB:   PRDATA = scan_rbase;
      default: PRDATA = 32'h0;
    endcase
  end

  // A Modbus coil write is applied first; then APB overrides each byte it strobes
  always_comb begin
    do_next = do_we ? ((do_reg & ~do_wmask) | (do_wdata & do_wmask)) : do_reg;
    for (int i = 0; i < 4; i++)
      if (wr_en && PADDR == A_DO && PSTRB[i]) do_next[i*8 +: 8] = PWDATA[i*8 +: 8];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      do_reg     <= 32'h0;
      timer      <= 32'h0;
      cfg0       <= 32'h0001_0000;
      cfg1       <= 32'h0080_0036;
      map_reg    <= 32'h0;
      irq        <= 3'b010;
      scan_ctrl  <= 32'h0001_0014;
      scan_idx   <= 32'h0;
      scan_entry <= 32'h0001_0400;
      scan_qty   <= 32'h0010_0010;
      scan_wbase <= 32'h0;
      scan_rbase <= 32'h0;
      di_s1      <= 32'h0;
      di_s2      <= 32'h0;
    end else begin
      do_reg <= do_next;
      di_s1  <= GPIO_DI;
      di_s2  <= di_s1;
      timer  <= (wr_en && PADDR == A_TIMER) ? PWDATA : timer + 32'd1;
      irq    <= (irq & ~((wr_en && PADDR == A_IRQ) ? PWDATA[2:0] : 3'b000))
                | {stat_crc_err, stat_tx_empty, frame_done};
      if (wr_en) begin
        case (PADDR)
          A_CFG0:  cfg0       <= PWDATA;
          A_CFG1:  cfg1       <= PWDATA;
          A_MAP:   map_reg    <= PWDATA;
          A_SCTRL: scan_ctrl  <= PWDATA;
          A_SIDX:  scan_idx   <= PWDATA;
          A_SENT:  scan_entry <= PWDATA;
          A_SQTY:  scan_qty   <= PWDATA;
          A_SWB:   scan_wbase <= PWDATA;
          A_SRB:   scan_rbase <= PWDATA;
          default: ;
        endcase
      end
    end
  end

  // 16x oversampling tick; a divisor of 0 behaves as 1
  assign div_m1 = (cfg1[15:0] == 16'd0) ? 16'd0 : cfg1[15:0] - 16'd1;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tick_cnt <= 16'd0;
      tick     <= 1'b0;
    end else if (tick_cnt >= div_m1) begin
      tick_cnt <= 16'd0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
      tick     <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= ST_IDLE;
      rx_os    <= 4'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'h0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= UART_RX;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        ST_IDLE:
          if (rx_s3 && !rx_s2) begin
            rx_state <= ST_START;
            rx_os    <= 4'd0;
          end
        ST_START:
          if (tick) begin
            if (rx_os == 4'd7) begin
              rx_os    <= 4'd0;
              rx_bit   <= 3'd0;
              rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
            end else rx_os <= rx_os + 4'd1;
          end
        ST_DATA:
          if (tick) begin
            if (rx_os == 4'd15) begin
              rx_os <= 4'd0;
              rx_sh <= {rx_s2, rx_sh[7:1]};
              if (rx_bit == 3'd7) rx_state <= ST_STOP;
              else rx_bit <= rx_bit + 3'd1;
            end else rx_os <= rx_os + 4'd1;
          end
        ST_STOP:
          if (tick) begin
            if (rx_os == 4'd15) begin
              rx_os    <= 4'd0;
              rx_state <= ST_IDLE;
              rx_valid <= rx_s2;
              rx_ferr  <= !rx_s2;
            end else rx_os <= rx_os + 4'd1;
          end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Silence threshold in ticks: max(1, sil*10 >> 8) bit times of 16 ticks each
  assign sil_x10   = {4'd0, cfg1[31:16]} * 20'd10;
  assign thr_bits  = (sil_x10[19:8] == 12'd0) ? 12'd1 : sil_x10[19:8];
  assign thr_ticks = {thr_bits, 4'd0};
  assign silent    = idle_cnt >= thr_ticks;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) idle_cnt <= 16'd0;
    else if (rx_state != ST_IDLE || !rx_s2) idle_cnt <= 16'd0;
    else if (tick && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
  end

  always_ff @(posedge PCLK) begin
    if (rx_valid && !fr_active && armed) fr_buf[0] <= rx_sh;
    else if (rx_valid && fr_active && fr_cnt < 4'd8) fr_buf[fr_cnt[2:0]] <= rx_sh;
  end

  assign addr_ok = (cfg0[7:0] == 8'h00) ? (fr_buf[0] != 8'h00 && fr_buf[0] <= 8'd247)
                                        : (fr_buf[0] == cfg0[7:0]);
  assign cmd_ok  = fr_cnt == 4'd8 && fr_buf[1] == 8'h05 && fr_buf[2] == 8'h00 && fr_buf[3] < 8'd32
                   && (fr_buf[4] == 8'hFF || fr_buf[4] == 8'h00) && fr_buf[5] == 8'h00;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fr_active    <= 1'b0;
      fr_cnt       <= 4'd0;
      fr_ovf       <= 1'b0;
      fr_discard   <= 1'b0;
      fr_crc       <= 16'hFFFF;
      armed        <= 1'b0;
      msg_good     <= 16'd0;
      msg_err      <= 16'd0;
      do_we        <= 1'b0;
      do_wmask     <= 32'h0;
      do_wdata     <= 32'h0;
      stat_crc_err <= 1'b0;
      frame_done   <= 1'b0;
      echo_start   <= 1'b0;
    end else begin
      do_we        <= 1'b0;
      stat_crc_err <= 1'b0;
      frame_done   <= 1'b0;
      echo_start   <= 1'b0;
      if (rx_ferr && fr_active) fr_discard <= 1'b1;
      if (rx_valid) begin
        if (fr_active) begin
          if (fr_cnt == 4'd8) fr_ovf <= 1'b1;
          else fr_cnt <= fr_cnt + 4'd1;
          fr_crc <= crc16_byte(fr_crc, rx_sh);
        end else if (armed) begin
          fr_active  <= 1'b1;
          armed      <= 1'b0;
          fr_cnt     <= 4'd1;
          fr_ovf     <= 1'b0;
          fr_discard <= 1'b0;
          fr_crc     <= crc16_byte(16'hFFFF, rx_sh);
        end
      end else if (silent) begin
        armed <= 1'b1;
        // End of frame: a correct CRC leaves a zero residual over data plus CRC bytes
        if (fr_active) begin
          fr_active <= 1'b0;
          if (!fr_discard && !fr_ovf) begin
            frame_done <= 1'b1;
            if (fr_crc != 16'h0000) begin
              stat_crc_err <= 1'b1;
              msg_err      <= sat_inc(msg_err);
            end else if (addr_ok) begin
              msg_good <= sat_inc(msg_good);
              if (!cfg0[16] && cmd_ok) begin
                do_we      <= 1'b1;
                do_wmask   <= 32'd1 << fr_buf[3][4:0];
                do_wdata   <= fr_buf[4][7] ? (32'd1 << fr_buf[3][4:0]) : 32'h0;
                echo_start <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (echo_start) tx_buf <= fr_buf;
  end

  assign stat_tx_empty = (tx_state == ST_IDLE) && (tx_left == 4'd0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_state <= ST_IDLE;
      UART_TX  <= 1'b1;
      tx_os    <= 4'd0;
      tx_bit   <= 3'd0;
      tx_left  <= 4'd0;
      tx_idx   <= 3'd0;
      tx_sh    <= 8'h0;
    end else begin
      case (tx_state)
        ST_IDLE:
          if (tx_left != 4'd0 && tick) begin
            tx_sh    <= tx_buf[tx_idx];
            UART_TX  <= 1'b0;
            tx_os    <= 4'd0;
            tx_state <= ST_START;
          end
        ST_START:
          if (tick) begin
            if (tx_os == 4'd15) begin
              tx_os    <= 4'd0;
              tx_bit   <= 3'd0;
              UART_TX  <= tx_sh[0];
              tx_state <= ST_DATA;
            end else tx_os <= tx_os + 4'd1;
          end
        ST_DATA:
          if (tick) begin
            if (tx_os == 4'd15) begin
              tx_os <= 4'd0;
              if (tx_bit == 3'd7) begin
                UART_TX  <= 1'b1;
                tx_state <= ST_STOP;
              end else begin
                tx_bit  <= tx_bit + 3'd1;
                tx_sh   <= {1'b0, tx_sh[7:1]};
                UART_TX <= tx_sh[1];
              end
            end else tx_os <= tx_os + 4'd1;
          end
        ST_STOP:
          if (tick) begin
            if (tx_os == 4'd15) begin
              tx_os    <= 4'd0;
              tx_state <= ST_IDLE;
              tx_left  <= tx_left - 4'd1;
              tx_idx   <= tx_idx + 3'd1;
            end else tx_os <= tx_os + 4'd1;
          end
        default: tx_state <= ST_IDLE;
      endcase
      if (echo_start) begin
        tx_left <= 4'd8;
        tx_idx  <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_modbus_gpio_converter.sv
// Directed bench for modbus_gpio_converter: CSR map, DI sync, timer, IRQ, FC05 frame with echo, CRC error frame.
`timescale 1ns/1ps
module tb_modbus_gpio_converter;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [11:0] PADDR = 12'h0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = 32'h0;
  logic [3:0]  PSTRB = 4'h0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        UART_RX = 1'b1;
  logic        UART_TX;
  logic [31:0] GPIO_DI = 32'h0;
  logic [31:0] GPIO_DO;

  localparam int DIV  = 8;
  localparam int BITC = 16 * DIV;
  localparam logic [63:0] FRAME_OK  = 64'h01_05_00_00_FF_00_8C_3A;
  localparam logic [63:0] FRAME_BAD = 64'h01_05_00_00_FF_00_8C_3B;
  localparam logic [11:0] RA [13] = '{12'h000, 12'h004, 12'h00C, 12'h018, 12'h010, 12'h014, 12'h01C,
                                      12'h020, 12'h02C, 12'h030, 12'h028, 12'h034, 12'h038};
  localparam logic [31:0] RE [13] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0080_0036, 32'h2,
                                      32'h0001_0014, 32'h0001_0400, 32'h0010_0010, 32'h0, 32'h0, 32'h0};

  int checks = 0, errors = 0;
  int we_cnt = 0, crc_cnt = 0, tx_n = 0;
  logic [31:0] we_mask = 32'h0, we_data = 32'h0;
  logic [7:0]  tx_bytes [16];
  logic [7:0]  mon_b;

  modbus_gpio_converter dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .UART_RX(UART_RX), .UART_TX(UART_TX), .GPIO_DI(GPIO_DI), .GPIO_DO(GPIO_DO)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (dut.do_we === 1'b1) begin
      we_cnt  <= we_cnt + 1;
      we_mask <= dut.do_wmask;
      we_data <= dut.do_wdata;
    end
    if (dut.stat_crc_err === 1'b1) crc_cnt <= crc_cnt + 1;
  end

  // Serial decoder on UART_TX, sampling mid-bit
  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESETn && UART_TX === 1'b0) begin
        repeat (BITC / 2) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) @(negedge PCLK);
          mon_b[i] = UART_TX;
        end
        repeat (BITC) @(negedge PCLK);
        if (tx_n < 16) tx_bytes[tx_n] = mon_b;
        tx_n = tx_n + 1;
      end
    end
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic uart_send_frame(input logic [63:0] f);
    logic [7:0] b;
    @(negedge PCLK);
    for (int k = 0; k < 8; k++) begin
      b = f[63 - 8*k -: 8];
      UART_RX = 1'b0;
      repeat (BITC) @(negedge PCLK);
      for (int i = 0; i < 8; i++) begin
        UART_RX = b[i];
        repeat (BITC) @(negedge PCLK);
      end
      UART_RX = 1'b1;
      repeat (BITC) @(negedge PCLK);
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    apb_read(12'h008, r);
    checks++;
    if (r > 32'd16) begin errors++; $display("FAIL reset_timer: got %0d, need <= 16", r); end
    for (int i = 0; i < 13; i++) begin
      apb_read(RA[i], r);
      checks++;
      if (r !== RE[i]) begin errors++; $display("FAIL reset_reg_%03h: got %08h, need %08h", RA[i], r, RE[i]); end
    end
    checks++;
    if (UART_TX !== 1'b1 || PREADY !== 1'b1 || PSLVERR !== 1'b0 || GPIO_DO !== 32'h0) begin
      errors++;
      $display("FAIL reset_pins: tx=%b ready=%b slverr=%b do=%08h, need 1 1 0 00000000", UART_TX, PREADY, PSLVERR, GPIO_DO);
    end
  endtask

  task automatic test_do_strobes;
    logic [31:0] r;
    apb_write(12'h000, 32'hDEADBEEF, 4'hF);
    apb_read(12'h000, r);
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL do_full: got %08h, need DEADBEEF", r); end
    apb_write(12'h000, 32'h12345678, 4'b0011);
    apb_read(12'h000, r);
    checks++;
    if (r !== 32'hDEAD5678) begin errors++; $display("FAIL do_strobe: got %08h, need DEAD5678", r); end
    checks++;
    if (GPIO_DO !== 32'hDEAD5678) begin errors++; $display("FAIL do_pins: got %08h, need DEAD5678", GPIO_DO); end
  endtask

  task automatic test_di_sync;
    logic [31:0] r;
    apb_write(12'h004, 32'hFFFFFFFF, 4'hF);
    apb_read(12'h004, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL di_write_ignored: got %08h, need 00000000", r); end
    @(negedge PCLK);
    PADDR = 12'h004;
    GPIO_DI = 32'hA5A55A5A;
    @(negedge PCLK);
    #1;
    checks++;
    if (PRDATA !== 32'h0) begin errors++; $display("FAIL di_one_clock: got %08h, need 00000000", PRDATA); end
    repeat (2) @(negedge PCLK);
    #1;
    checks++;
    if (PRDATA !== 32'hA5A55A5A) begin errors++; $display("FAIL di_three_clocks: got %08h, need A5A55A5A", PRDATA); end
  endtask

  task automatic test_timer;
    logic [31:0] r1, r2;
    apb_write(12'h008, 32'h000000F0, 4'hF);
    apb_read(12'h008, r1);
    checks++;
    if (r1 < 32'hF0 || r1 > 32'hF3) begin errors++; $display("FAIL timer_load: got %08h, need 000000F0..000000F3", r1); end
    repeat (10) @(negedge PCLK);
    apb_read(12'h008, r2);
    checks++;
    if (r2 <= r1) begin errors++; $display("FAIL timer_count: got %08h, need > %08h", r2, r1); end
  endtask

  task automatic test_irq;
    logic [31:0] r;
    apb_write(12'h01C, 32'hFFFFFFFF, 4'hF);
    apb_read(12'h01C, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL irq_set_priority: got %08h, need 00000002", r); end
    force dut.stat_tx_empty = 1'b0;
    apb_write(12'h01C, 32'h00000002, 4'hF);
    apb_read(12'h01C, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL irq_w1c: got %08h, need 00000000", r); end
    release dut.stat_tx_empty;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_scan_regs;
    logic [31:0] r;
    apb_write(12'h02C, 32'h01000302, 4'hF);
    apb_write(12'h020, 32'hCAFE0001, 4'hF);
    apb_write(12'h038, 32'h89ABCDEF, 4'hF);
    apb_write(12'h018, 32'h0000BEEF, 4'hF);
    apb_write(12'h024, 32'hFFFFFFFF, 4'hF);
    apb_read(12'h02C, r);
    checks++;
    if (r !== 32'h01000302) begin errors++; $display("FAIL scan_entry: got %08h, need 01000302", r); end
    apb_read(12'h020, r);
    checks++;
    if (r !== 32'hCAFE0001) begin errors++; $display("FAIL scan_ctrl: got %08h, need CAFE0001", r); end
    apb_read(12'h038, r);
    checks++;
    if (r !== 32'h89ABCDEF) begin errors++; $display("FAIL scan_rbase: got %08h, need 89ABCDEF", r); end
    apb_read(12'h018, r);
    checks++;
    if (r !== 32'h0000BEEF) begin errors++; $display("FAIL map: got %08h, need 0000BEEF", r); end
    apb_read(12'h024, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL unmapped: got %08h, need 00000000", r); end
  endtask

  task automatic test_fc05_frame;
    logic [31:0] r;
    logic [7:0]  e;
    int we0, i;
    apb_write(12'h010, 32'h0, 4'hF);
    apb_write(12'h014, 32'h0080_0000 | DIV, 4'hF);
    apb_write(12'h000, 32'h0, 4'hF);
    repeat (5 * 10 * BITC) @(negedge PCLK);
    we0 = we_cnt;
    uart_send_frame(FRAME_OK);
    i = 0;
    while (i < 4000 && we_cnt == we0) begin @(negedge PCLK); i++; end
    checks++;
    if (we_cnt != we0 + 1) begin errors++; $display("FAIL fc05_do_we: got %0d pulses, need 1", we_cnt - we0); end
    checks++;
    if (we_mask !== 32'h1 || we_data !== 32'h1) begin
      errors++; $display("FAIL fc05_mask_data: got %08h/%08h, need 00000001/00000001", we_mask, we_data);
    end
    apb_read(12'h000, r);
    checks++;
    if (r !== 32'h1 || GPIO_DO[0] !== 1'b1) begin errors++; $display("FAIL fc05_do: got %08h pin0=%b, need 00000001 1", r, GPIO_DO[0]); end
    apb_read(12'h00C, r);
    checks++;
    if (r !== 32'h0000_0001) begin errors++; $display("FAIL fc05_msg: got %08h, need 00000001", r); end
    i = 0;
    while (i < 20000 && tx_n < 8) begin @(negedge PCLK); i++; end
    checks++;
    if (tx_n != 8) begin errors++; $display("FAIL echo_count: got %0d bytes, need 8", tx_n); end
    for (int k = 0; k < 8; k++) begin
      e = FRAME_OK[63 - 8*k -: 8];
      checks++;
      if (tx_bytes[k] !== e) begin errors++; $display("FAIL echo_byte%0d: got %02h, need %02h", k, tx_bytes[k], e); end
    end
    apb_read(12'h01C, r);
    checks++;
    if (r !== 32'h3) begin errors++; $display("FAIL fc05_irq: got %08h, need 00000003", r); end
    repeat (4 * BITC) @(negedge PCLK);
  endtask

  task automatic test_crc_error;
    logic [31:0] r;
    int c0, we0, i;
    c0 = crc_cnt;
    we0 = we_cnt;
    uart_send_frame(FRAME_BAD);
    i = 0;
    while (i < 4000 && crc_cnt == c0) begin @(negedge PCLK); i++; end
    checks++;
    if (crc_cnt != c0 + 1) begin errors++; $display("FAIL crc_pulse: got %0d pulses, need 1", crc_cnt - c0); end
    apb_read(12'h00C, r);
    checks++;
    if (r !== 32'h0001_0001) begin errors++; $display("FAIL crc_msg: got %08h, need 00010001", r); end
    apb_read(12'h000, r);
    checks++;
    if (r !== 32'h1 || we_cnt != we0) begin errors++; $display("FAIL crc_do: got %08h we=%0d, need 00000001 we=0", r, we_cnt - we0); end
    repeat (2000) @(negedge PCLK);
    checks++;
    if (tx_n != 8 || UART_TX !== 1'b1) begin errors++; $display("FAIL crc_no_tx: got %0d bytes tx=%b, need 8 1", tx_n, UART_TX); end
  endtask

  initial begin
    repeat (4) @(negedge PCLK);
    PRESETn = 1'b1;
    test_reset();
    test_do_strobes();
    test_di_sync();
    test_timer();
    test_irq();
    test_scan_regs();
    test_fc05_frame();
    test_crc_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
